// File: rtl/ethernet_pkg.sv
// Shared Ethernet types and constants, plus the receive-side parser state
// encoding and destination-address filter.
package ethernet_pkg;

    typedef logic [5:0][7:0] macaddr_t;

    typedef struct packed {
        macaddr_t    h_dest;
        macaddr_t    h_source;
        logic [15:0] h_proto;
    } ethhdr;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [10:0] ETH_MIN_LEN   = 11'd64;
    localparam logic [10:0] ETH_MAX_LEN   = 11'd1518;
    localparam macaddr_t    ETH_BCAST     = 48'hFFFF_FFFF_FFFF;
    localparam int          ETH_HDR_BYTES = 14;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_PREAMBLE,
        RX_HEADER,
        RX_PAYLOAD,
        RX_DROP
    } eth_rx_state_t;

    function automatic logic eth_dst_match(ethhdr h, macaddr_t mac, logic promisc);
        return promisc || (h.h_dest == mac) || (h.h_dest == ETH_BCAST);
    endfunction

endpackage

// File: rtl/eth_rx_parser_if.sv
// Byte-stream receive bus into the parser and its decoded header / payload outputs.
interface eth_rx_parser_if;
    import ethernet_pkg::*;

    logic [7:0] rx_data;
    logic       rx_dv;
    logic       rx_er;
    ethhdr      hdr;
    logic       hdr_valid;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_err;
    logic       stat_drop;

    modport master (
        output rx_data, rx_dv, rx_er,
        input  hdr, hdr_valid, m_data, m_valid, m_last, m_err, stat_drop
    );

    modport slave (
        input  rx_data, rx_dv, rx_er,
        output hdr, hdr_valid, m_data, m_valid, m_last, m_err, stat_drop
    );
endinterface

// File: rtl/eth_fcs_strip.sv
// Five-byte delay line: payload leaves only once five newer bytes exist, so the
// four FCS bytes are still held (and dropped) when the frame ends.
module eth_fcs_strip (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       flush_i,
    output logic       full_o,
    output logic [7:0] m_data_o,
    output logic       m_valid_o,
    output logic       m_last_o
);
    logic [4:0][7:0] sr_q;
    logic [2:0]      fill_q, fill_d;
    logic [7:0]      m_data_q, m_data_d;
    logic            m_valid_q, m_valid_d;
    logic            m_last_q, m_last_d;

    assign full_o    = (fill_q == 3'd5);
    assign m_data_o  = m_data_q;
    assign m_valid_o = m_valid_q;
    assign m_last_o  = m_last_q;

    always_comb begin
        fill_d    = fill_q;
        m_data_d  = 8'h00;
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
        if (flush_i) begin
            fill_d = 3'd0;
            if (full_o) begin
                m_valid_d = 1'b1;
                m_last_d  = 1'b1;
                m_data_d  = sr_q[4];
            end
        end else if (push_i) begin
            if (full_o) begin
                m_valid_d = 1'b1;
                m_data_d  = sr_q[4];
            end else begin
                fill_d = fill_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) sr_q <= {sr_q[3:0], data_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q    <= 3'd0;
            m_data_q  <= 8'h00;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            fill_q    <= fill_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end
endmodule

// File: rtl/eth_rx_parser.sv
// Receive framer: preamble/SFD hunt, 14-byte header decode with destination
// filtering, and FCS-stripped payload streaming with a length/error verdict.
module eth_rx_parser
    import ethernet_pkg::*;
#(
    parameter bit PROMISC = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  macaddr_t       local_mac,
    eth_rx_parser_if.slave bus
);
    eth_rx_state_t state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [10:0]   len_q, len_d, len_inc;
    logic          err_q, err_d;
    ethhdr         shadow_q, shadow_d;
    ethhdr         hdr_q, hdr_d;
    logic          hdr_valid_q, hdr_valid_d;
    logic          stat_drop_q, stat_drop_d;
    logic          m_err_q, m_err_d;
    logic          push, flush, full;

    assign len_inc = (&len_q) ? len_q : len_q + 11'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        err_d       = err_q;
        shadow_d    = shadow_q;
        hdr_d       = hdr_q;
        hdr_valid_d = 1'b0;
        stat_drop_d = 1'b0;
        m_err_d     = 1'b0;
        push        = 1'b0;
        flush       = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (bus.rx_dv) begin
                    err_d   = bus.rx_er;
                    state_d = (bus.rx_data == ETH_PREAMBLE) ? RX_PREAMBLE : RX_DROP;
                end
            end
            RX_PREAMBLE: begin
                if (!bus.rx_dv) begin
                    stat_drop_d = 1'b1;
                    state_d     = RX_IDLE;
                end else begin
                    err_d = err_q | bus.rx_er;
                    if (bus.rx_data == ETH_SFD) begin
                        state_d = RX_HEADER;
                        cnt_d   = 4'd0;
                        len_d   = 11'd0;
                    end else if (bus.rx_data != ETH_PREAMBLE) begin
                        state_d = RX_DROP;
                    end
                end
            end
            RX_HEADER: begin
                if (!bus.rx_dv) begin
                    stat_drop_d = 1'b1;
                    state_d     = RX_IDLE;
                end else begin
                    err_d    = err_q | bus.rx_er;
                    len_d    = len_inc;
                    cnt_d    = cnt_q + 4'd1;
                    shadow_d = {shadow_q[8*ETH_HDR_BYTES-9:0], bus.rx_data};
                    // Only an accepted header becomes visible on hdr.
                    if (cnt_q == 4'(ETH_HDR_BYTES - 1)) begin
                        if (eth_dst_match(shadow_d, local_mac, PROMISC)) begin
                            hdr_d       = shadow_d;
                            hdr_valid_d = 1'b1;
                            state_d     = RX_PAYLOAD;
                        end else begin
                            stat_drop_d = 1'b1;
                            state_d     = RX_DROP;
                        end
                    end
                end
            end
            RX_PAYLOAD: begin
                if (bus.rx_dv) begin
                    push  = 1'b1;
                    len_d = len_inc;
                    err_d = err_q | bus.rx_er;
                end else begin
                    flush   = 1'b1;
                    state_d = RX_IDLE;
                    if (full) begin
                        m_err_d = err_q || (len_q < ETH_MIN_LEN) || (len_q > ETH_MAX_LEN);
                    end else begin
                        stat_drop_d = 1'b1;
                    end
                end
            end
            RX_DROP: begin
                if (!bus.rx_dv) state_d = RX_IDLE;
            end
            default: state_d = RX_DROP;
        endcase
    end

    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    // Reset lands in DROP so a frame already on the wire is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RX_DROP;
            cnt_q       <= 4'd0;
            len_q       <= 11'd0;
            err_q       <= 1'b0;
            hdr_q       <= '0;
            hdr_valid_q <= 1'b0;
            stat_drop_q <= 1'b0;
            m_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            err_q       <= err_d;
            hdr_q       <= hdr_d;
            hdr_valid_q <= hdr_valid_d;
            stat_drop_q <= stat_drop_d;
            m_err_q     <= m_err_d;
        end
    end

    eth_fcs_strip u_strip (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .data_i    (bus.rx_data),
        .flush_i   (flush),
        .full_o    (full),
        .m_data_o  (bus.m_data),
        .m_valid_o (bus.m_valid),
        .m_last_o  (bus.m_last)
    );

    assign bus.hdr       = hdr_q;
    assign bus.hdr_valid = hdr_valid_q;
    assign bus.stat_drop = stat_drop_q;
    assign bus.m_err     = m_err_q;
endmodule

// File: tb/tb_eth_rx_parser.sv
// Directed bench for eth_rx_parser: unicast, filtering, runts, errors,
// preamble faults, back-to-back frames and reset in mid-frame.
module tb_eth_rx_parser;
    import ethernet_pkg::*;

    localparam logic [47:0] MAC_LOCAL = 48'h02_00_00_00_00_01;
    localparam logic [47:0] MAC_OTHER = 48'h02_00_00_00_00_09;
    localparam logic [47:0] MAC_BC    = 48'hFF_FF_FF_FF_FF_FF;

    logic     clk = 1'b0;
    logic     rst_n;
    macaddr_t local_mac;

    eth_rx_parser_if bus();

    eth_rx_parser #(.PROMISC(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .local_mac (local_mac),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Event collector: observes outputs mid-cycle, away from the rising edge.
    int          hv_cnt = 0, sd_cnt = 0, last_cnt = 0, lerr_cnt = 0, both_cnt = 0;
    logic [7:0]  last_data = 8'h00;
    logic [15:0] hv_proto = 16'h0;
    macaddr_t    hv_dest = '0;
    logic [7:0]  beats[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.hdr_valid) begin
                hv_cnt++;
                hv_proto = bus.hdr.h_proto;
                hv_dest  = bus.hdr.h_dest;
            end
            if (bus.stat_drop) sd_cnt++;
            if (bus.stat_drop && bus.m_last) both_cnt++;
            if (bus.m_valid) begin
                beats.push_back(bus.m_data);
                if (bus.m_last) begin
                    last_cnt++;
                    last_data = bus.m_data;
                    if (bus.m_err) lerr_cnt++;
                end
            end
        end
    end

    int b_hv, b_sd, b_last, b_lerr, b_both, b_beats;

    task automatic snap();
        b_hv = hv_cnt; b_sd = sd_cnt; b_last = last_cnt;
        b_lerr = lerr_cnt; b_both = both_cnt; b_beats = beats.size();
    endtask

    function automatic int payload_bad(input int start, input int plen, input int pstart);
        if (beats.size() < start + plen) return -2;
        for (int i = 0; i < plen; i++)
            if (beats[start + i] !== 8'(pstart + i)) return i;
        return -1;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic er);
        @(negedge clk);
        bus.rx_dv = 1'b1; bus.rx_data = b; bus.rx_er = er;
    endtask

    task automatic end_frame(input int gap);
        @(negedge clk);
        bus.rx_dv = 1'b0; bus.rx_er = 1'b0; bus.rx_data = 8'h00;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic send_preamble();
        repeat (7) send_byte(8'h55, 1'b0);
        send_byte(8'hD5, 1'b0);
    endtask

    // Post-SFD bytes: header, payload (pstart+i), FCS; cut<0 sends everything.
    task automatic send_body(input logic [47:0] dst, input int plen, input int pstart,
                             input int er_at, input int cut);
        logic [7:0] fb[$];
        logic [47:0] src;
        src = 48'h02_00_00_00_00_02;
        for (int i = 5; i >= 0; i--) fb.push_back(dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) fb.push_back(src[8*i +: 8]);
        fb.push_back(8'h08); fb.push_back(8'h00);
        for (int i = 0; i < plen; i++) fb.push_back(8'(pstart + i));
        fb.push_back(8'hDE); fb.push_back(8'hAD); fb.push_back(8'hBE); fb.push_back(8'hEF);
        for (int i = 0; i < fb.size() && (cut < 0 || i < cut); i++)
            send_byte(fb[i], (i == er_at));
    endtask

    task automatic settle();
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.rx_dv = 1'b0; bus.rx_er = 1'b0; bus.rx_data = 8'h00;
        local_mac = MAC_LOCAL;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({bus.hdr_valid, bus.m_valid, bus.m_last, bus.m_err, bus.stat_drop} !== 5'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 00000", {bus.hdr_valid, bus.m_valid, bus.m_last, bus.m_err, bus.stat_drop}); end
        n_cmp++; if (bus.hdr !== '0) begin n_bad++; $display("FAIL reset_hdr: got %h want 0", bus.hdr); end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_unicast();
        snap();
        send_preamble(); send_body(MAC_LOCAL, 46, 0, -1, -1); end_frame(1); settle();
        n_cmp++; if (hv_cnt - b_hv !== 1) begin n_bad++; $display("FAIL uni_hdr_valid: got %0d want 1", hv_cnt - b_hv); end
        n_cmp++; if (hv_proto !== 16'h0800) begin n_bad++; $display("FAIL uni_proto: got %h want 0800", hv_proto); end
        n_cmp++; if (hv_dest !== MAC_LOCAL) begin n_bad++; $display("FAIL uni_dest: got %h want %h", hv_dest, MAC_LOCAL); end
        n_cmp++; if (bus.hdr.h_source !== 48'h02_00_00_00_00_02) begin n_bad++; $display("FAIL uni_src: got %h want 020000000002", bus.hdr.h_source); end
        n_cmp++; if (beats.size() - b_beats !== 46) begin n_bad++; $display("FAIL uni_beats: got %0d want 46", beats.size() - b_beats); end
        n_cmp++; if (payload_bad(b_beats, 46, 0) !== -1) begin n_bad++; $display("FAIL uni_data: bad index %0d want -1", payload_bad(b_beats, 46, 0)); end
        n_cmp++; if (last_cnt - b_last !== 1) begin n_bad++; $display("FAIL uni_last: got %0d want 1", last_cnt - b_last); end
        n_cmp++; if (last_data !== 8'h2D) begin n_bad++; $display("FAIL uni_last_data: got %h want 2d", last_data); end
        n_cmp++; if (lerr_cnt - b_lerr !== 0) begin n_bad++; $display("FAIL uni_err: got %0d want 0", lerr_cnt - b_lerr); end
        n_cmp++; if (sd_cnt - b_sd !== 0) begin n_bad++; $display("FAIL uni_drop: got %0d want 0", sd_cnt - b_sd); end
    endtask

    task automatic test_filter();
        snap();
        send_preamble(); send_body(MAC_OTHER, 46, 0, -1, -1); end_frame(1); settle();
        n_cmp++; if (hv_cnt - b_hv !== 0) begin n_bad++; $display("FAIL filt_hdr_valid: got %0d want 0", hv_cnt - b_hv); end
        n_cmp++; if (beats.size() - b_beats !== 0) begin n_bad++; $display("FAIL filt_beats: got %0d want 0", beats.size() - b_beats); end
        n_cmp++; if (sd_cnt - b_sd !== 1) begin n_bad++; $display("FAIL filt_drop: got %0d want 1", sd_cnt - b_sd); end
        snap();
        send_preamble(); send_body(MAC_BC, 46, 8'h30, -1, -1); end_frame(1); settle();
        n_cmp++; if (hv_cnt - b_hv !== 1) begin n_bad++; $display("FAIL bc_hdr_valid: got %0d want 1", hv_cnt - b_hv); end
        n_cmp++; if (payload_bad(b_beats, 46, 8'h30) !== -1 || beats.size() - b_beats !== 46) begin n_bad++; $display("FAIL bc_data: got %0d beats want 46", beats.size() - b_beats); end
        n_cmp++; if (last_cnt - b_last !== 1 || lerr_cnt - b_lerr !== 0) begin n_bad++; $display("FAIL bc_last: got last %0d err %0d want 1 0", last_cnt - b_last, lerr_cnt - b_lerr); end
    endtask

    task automatic test_runt();
        snap();
        send_preamble(); send_body(MAC_LOCAL, 10, 8'h40, -1, -1); end_frame(1); settle();
        n_cmp++; if (beats.size() - b_beats !== 10) begin n_bad++; $display("FAIL runt_beats: got %0d want 10", beats.size() - b_beats); end
        n_cmp++; if (payload_bad(b_beats, 10, 8'h40) !== -1) begin n_bad++; $display("FAIL runt_data: bad index %0d want -1", payload_bad(b_beats, 10, 8'h40)); end
        n_cmp++; if (last_cnt - b_last !== 1) begin n_bad++; $display("FAIL runt_last: got %0d want 1", last_cnt - b_last); end
        n_cmp++; if (lerr_cnt - b_lerr !== 1) begin n_bad++; $display("FAIL runt_err: got %0d want 1", lerr_cnt - b_lerr); end
        snap();
        send_preamble(); send_body(MAC_LOCAL, 46, 0, -1, 16); end_frame(1); settle();
        n_cmp++; if (last_cnt - b_last !== 0) begin n_bad++; $display("FAIL short_last: got %0d want 0", last_cnt - b_last); end
        n_cmp++; if (sd_cnt - b_sd !== 1) begin n_bad++; $display("FAIL short_drop: got %0d want 1", sd_cnt - b_sd); end
        n_cmp++; if (beats.size() - b_beats !== 0) begin n_bad++; $display("FAIL short_beats: got %0d want 0", beats.size() - b_beats); end
    endtask

    task automatic test_errors();
        snap();
        send_preamble(); send_body(MAC_LOCAL, 46, 0, 14 + 20, -1); end_frame(1); settle();
        n_cmp++; if (beats.size() - b_beats !== 46) begin n_bad++; $display("FAIL rxer_beats: got %0d want 46", beats.size() - b_beats); end
        n_cmp++; if (last_cnt - b_last !== 1 || lerr_cnt - b_lerr !== 1) begin n_bad++; $display("FAIL rxer_err: got last %0d err %0d want 1 1", last_cnt - b_last, lerr_cnt - b_lerr); end
        snap();
        send_preamble(); send_body(MAC_LOCAL, 1582, 0, -1, -1); end_frame(1); settle();
        n_cmp++; if (beats.size() - b_beats !== 1582) begin n_bad++; $display("FAIL long_beats: got %0d want 1582", beats.size() - b_beats); end
        n_cmp++; if (last_cnt - b_last !== 1 || lerr_cnt - b_lerr !== 1) begin n_bad++; $display("FAIL long_err: got last %0d err %0d want 1 1", last_cnt - b_last, lerr_cnt - b_lerr); end
    endtask

    task automatic test_bad_preamble();
        snap();
        send_byte(8'h55, 1'b0); send_byte(8'h57, 1'b0);
        send_preamble(); send_body(MAC_BC, 46, 0, -1, -1); end_frame(2); settle();
        n_cmp++; if (hv_cnt - b_hv !== 0 || beats.size() - b_beats !== 0) begin n_bad++; $display("FAIL badpre_out: got hv %0d beats %0d want 0 0", hv_cnt - b_hv, beats.size() - b_beats); end
        snap();
        send_byte(8'hD5, 1'b0); send_body(MAC_BC, 46, 0, -1, -1); end_frame(2); settle();
        n_cmp++; if (hv_cnt - b_hv !== 0 || beats.size() - b_beats !== 0) begin n_bad++; $display("FAIL baresfd_out: got hv %0d beats %0d want 0 0", hv_cnt - b_hv, beats.size() - b_beats); end
    endtask

    task automatic test_back_to_back();
        snap();
        send_preamble(); send_body(MAC_LOCAL, 46, 8'h10, -1, -1); end_frame(1);
        send_preamble(); send_body(MAC_LOCAL, 46, 8'h80, -1, -1); end_frame(1); settle();
        n_cmp++; if (hv_cnt - b_hv !== 2) begin n_bad++; $display("FAIL b2b_hdr_valid: got %0d want 2", hv_cnt - b_hv); end
        n_cmp++; if (beats.size() - b_beats !== 92) begin n_bad++; $display("FAIL b2b_beats: got %0d want 92", beats.size() - b_beats); end
        n_cmp++; if (payload_bad(b_beats, 46, 8'h10) !== -1 || payload_bad(b_beats + 46, 46, 8'h80) !== -1) begin n_bad++; $display("FAIL b2b_data: bad index %0d / %0d want -1", payload_bad(b_beats, 46, 8'h10), payload_bad(b_beats + 46, 46, 8'h80)); end
        n_cmp++; if (last_cnt - b_last !== 2 || lerr_cnt - b_lerr !== 0) begin n_bad++; $display("FAIL b2b_last: got last %0d err %0d want 2 0", last_cnt - b_last, lerr_cnt - b_lerr); end
        n_cmp++; if (sd_cnt - b_sd !== 0 || both_cnt - b_both !== 0) begin n_bad++; $display("FAIL b2b_drop: got drop %0d both %0d want 0 0", sd_cnt - b_sd, both_cnt - b_both); end
    endtask

    task automatic test_reset_midframe();
        send_preamble(); send_body(MAC_LOCAL, 46, 0, -1, 14 + 30);
        #1;
        n_cmp++; if (bus.m_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_valid: got %b want 1", bus.m_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.hdr_valid, bus.m_valid, bus.m_last, bus.m_err, bus.stat_drop} !== 5'b0 || bus.hdr !== '0) begin n_bad++; $display("FAIL rst_mid_outputs: got %b hdr %h want 00000 0", {bus.hdr_valid, bus.m_valid, bus.m_last, bus.m_err, bus.stat_drop}, bus.hdr); end
        for (int i = 0; i < 3; i++) send_byte(8'(30 + i), 1'b0);
        @(negedge clk); rst_n = 1'b1;
        snap();
        for (int i = 0; i < 20; i++) send_byte(8'(33 + i), 1'b0);
        end_frame(1); settle();
        n_cmp++; if (hv_cnt - b_hv !== 0 || beats.size() - b_beats !== 0 || last_cnt - b_last !== 0) begin n_bad++; $display("FAIL rst_remainder: got hv %0d beats %0d last %0d want 0 0 0", hv_cnt - b_hv, beats.size() - b_beats, last_cnt - b_last); end
        snap();
        send_preamble(); send_body(MAC_LOCAL, 46, 8'h20, -1, -1); end_frame(1); settle();
        n_cmp++; if (hv_cnt - b_hv !== 1 || beats.size() - b_beats !== 46) begin n_bad++; $display("FAIL rst_next_frame: got hv %0d beats %0d want 1 46", hv_cnt - b_hv, beats.size() - b_beats); end
        n_cmp++; if (payload_bad(b_beats, 46, 8'h20) !== -1 || lerr_cnt - b_lerr !== 0 || last_cnt - b_last !== 1) begin n_bad++; $display("FAIL rst_next_data: bad index %0d err %0d want -1 0", payload_bad(b_beats, 46, 8'h20), lerr_cnt - b_lerr); end
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_filter();
        test_runt();
        test_errors();
        test_bad_preamble();
        test_back_to_back();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/eth_rx_parser.md
# eth_rx_parser

Receive-side Ethernet framer: consumes a GMII-style byte stream, locates preamble/SFD, decodes the 14-byte header into an `ethhdr`, filters on destination MAC, and streams the payload with the 4-byte FCS stripped. It sits between the MAC/PHY byte interface and the upper-layer (IP/TLP-over-UDP) receive path. It is the receive counterpart of the header construction done by `eth_init` on the transmit side.

## Interface

Parameters:
- `PROMISC`, default 0: 1 = accept every destination MAC.

Ports:
- `clk`  in  1: the single clock; all inputs are sampled on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `local_mac`  in  `macaddr_t`: station address; must be static during a frame.
- `rx_data`  in  8: received byte.
- `rx_dv`  in  1: byte valid; a frame is contiguous while this is high.
- `rx_er`  in  1: PHY error flag; qualified by `rx_dv`.
- `hdr`  out  `ethhdr`: decoded header; held until the next accepted frame.
- `hdr_valid`  out  1: 1-cycle pulse when an accepted header is complete.
- `m_data`  out  8: payload byte.
- `m_valid`  out  1: payload byte valid. There is no backpressure.
- `m_last`  out  1: final payload byte of the frame.
- `m_err`  out  1: meaningful only with `m_last`; the frame is bad.
- `stat_drop`  out  1: 1-cycle pulse for each filtered, malformed or runt frame.

## Operation

**States:** IDLE, PREAMBLE, HEADER, PAYLOAD, DROP.

- **IDLE**, when `rx_dv` is high:
  - `ETH_PREAMBLE` (0x55) → PREAMBLE.
  - Any other byte, including a bare `ETH_SFD`, → DROP.
- **PREAMBLE:**
  - 0x55 → stay.
  - `ETH_SFD` (0xD5) → HEADER, with the byte count cleared.
  - Other → DROP.
- **HEADER:**
  - Bytes shift into `hdr` MSB-first: the first byte lands at `h_dest[5]`; the 14th completes `h_proto`.
  - On the 14th byte:
    - Accept if `PROMISC`, `h_dest==local_mac`, or `h_dest==48'hFFFF_FFFF_FFFF`. Accept → PAYLOAD and pulse `hdr_valid`.
    - Otherwise → DROP and pulse `stat_drop`.
  - `hdr` updates only for accepted frames; the shadow register is internal.
- **PAYLOAD:**
  - Each byte enters a 5-deep byte FIFO (shift register, fill 0..5).
  - When a byte arrives with fill==5, the oldest byte is emitted (`m_valid`=1, `m_last`=0).
- **End of frame** (`rx_dv` falls):
  - In PAYLOAD with fill==5: emit the oldest byte with `m_last`=1 and `m_err`. The remaining 4 bytes (FCS) are discarded.
  - In PAYLOAD with fill<5 (runt), or in PREAMBLE or HEADER: no `m_last`; pulse `stat_drop`. A prior `hdr_valid` is then orphaned, so consumers commit only on `m_last`.
  - In all cases → IDLE.
- **DROP:** wait for `rx_dv` low, then → IDLE. No output.

**Length and error:**
- `len` is an 11-bit saturating counter (max 2047) of bytes from the first `h_dest` byte through the final FCS byte.
- `m_err` = (`rx_er` was seen in any cycle of the frame) OR `len < ETH_MIN_LEN` (64) OR `len > ETH_MAX_LEN` (1518).
- FCS is not checked in this block.

**Reset:**
- All outputs are reset to 0; `hdr` resets to 0.
- The state after reset is DROP, so a frame already in progress at reset release is discarded.

## Timing

- All outputs are registered. An event caused by the byte sampled at edge N is visible after edge N.
- `hdr_valid` is high during the cycle after the 14th header byte is sampled.
- Payload byte k is output the cycle after byte k+5 is sampled. The last payload byte is output the cycle after the first sample with `rx_dv`=0.
- Because of this ordering, `hdr_valid` always precedes the first `m_valid` of the frame by at least 5 cycles.
- Back-to-back frames separated by a single idle cycle must work: the `m_last` cycle coincides with IDLE accepting a new 0x55.
- An `rx_dv` gap of one cycle always terminates the frame.
- `stat_drop` and `m_last` are never asserted in the same cycle.

## Structure

- Extend `ethernet_pkg` with:
  - `ETH_BCAST` = 48'hFFFF_FFFF_FFFF.
  - `ETH_HDR_BYTES` = 14.
  - `typedef enum logic [2:0] eth_rx_state_t`.
  - Function `eth_dst_match(ethhdr, macaddr_t, promisc)`.
- Reuse `ethhdr`, `macaddr_t`, `ETH_MIN_LEN` and `ETH_MAX_LEN` from `ethernet_pkg`.
- One sub-module: `eth_fcs_strip`, the 5-deep delay line with fill count, `flush` input, and `m_valid`/`m_last` generation.

## Test plan

1. **Unicast:**
   - Stimulus: 7×0x55, 0xD5; dst = `local_mac` = 02:00:00:00:00:01; src 02:00:00:00:00:02; proto 0x0800; 46 payload bytes 0x00..0x2D; 4 FCS bytes.
   - Required: `hdr_valid` once with `hdr.h_proto`=0x0800; 46 `m_valid` beats 0x00..0x2D; `m_last` on 0x2D; `m_err`=0.
2. **Filter:**
   - Stimulus: same frame with dst 02:00:00:00:00:09 and `PROMISC`=0.
   - Required: no `hdr_valid`, no `m_valid`, one `stat_drop`.
   - Stimulus: dst FF:FF:FF:FF:FF:FF.
   - Required: accepted.
3. **Runt / short:**
   - Stimulus: 10-byte payload (len 28).
   - Required: 10 beats, `m_last` with `m_err`=1.
   - Stimulus: frame ending after 16 bytes post-SFD.
   - Required: no `m_last`, `stat_drop` pulse.
4. **Errors:**
   - Stimulus: `rx_er` for one cycle mid-payload of a 64-byte frame.
   - Required: `m_err`=1 on `m_last`.
   - Stimulus: 1600-byte frame.
   - Required: `m_err`=1.
5. **Bad preamble / back-to-back:**
   - Stimulus: 0x55, 0x57, ...
   - Required: DROP, no output.
   - Stimulus: two valid 64-byte frames separated by 1 idle cycle.
   - Required: both delivered intact.
6. **Reset mid-frame:**
   - Stimulus: assert `rst_n`=0 during PAYLOAD.
   - Required: outputs go to 0 immediately.
   - Stimulus: release while `rx_dv` is still high.
   - Required: remainder ignored; the next frame is delivered correctly.
